// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: the pipeline tag record
// and the forwarding select encoding (SEL_RF = register file).
package fwd_pkg;

  localparam int RD_W   = 8;
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            is_load;
    logic [RD_W-1:0] rd;
  } tag_t;

  function automatic logic wr_live(tag_t t);
    return t.valid & t.regwrite & (t.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority comparator: one EX source against tags 1..DEPTH, youngest wins.
// In: src, used, live[k], rd[k]. Out: sel (0 = register file, k = stage k).
module fwd_match
  import fwd_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int SW    = 2
) (
  input  logic [AW-1:0]               src,
  input  logic                        used,
  input  logic [DEPTH:1]              live,
  input  logic [DEPTH:1][RD_W-1:0]    rd,
  output logic [SW-1:0]               sel
);

  always_comb begin
    sel = SW'(SEL_RF);
    if (used && src != '0) begin
      // walk oldest to youngest so the smallest k overwrites last
      for (int k = DEPTH; k >= 1; k--) begin
        if (live[k] && rd[k] == RD_W'(src)) sel = SW'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects for EX and load-use stall for ID; stall_cnt only
// when FWD_STALL_CNT_EN is defined. Ports: clk, rst_n, id_*, ext_stall, flush -> fwd_sel, load_use_stall, stall_cnt.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int AW         = 5,
  parameter  int DEPTH      = 2,
  parameter  int LOAD_STAGE = 2,
  localparam int SW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic [AW-1:0]         id_rd,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic                  ext_stall,
  input  logic                  flush,
  output logic [NUM_SRC*SW-1:0] fwd_sel,
  output logic                  load_use_stall,
  output logic [15:0]           stall_cnt
);

  tag_t                  tag_q [0:DEPTH];
  tag_t                  tag_d [0:DEPTH];
  logic [NUM_SRC*AW-1:0] ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0]    ex_used_q, ex_used_d;

  logic [DEPTH:1]            live;
  logic [DEPTH:1][RD_W-1:0]  rd_k;
  logic                      ld_hit;

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      live[k] = wr_live(tag_q[k]);
      rd_k[k] = tag_q[k].rd;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .AW   (AW),
      .DEPTH(DEPTH),
      .SW   (SW)
    ) u_match (
      .src (ex_src_q[i*AW +: AW]),
      .used(ex_used_q[i]),
      .live(live),
      .rd  (rd_k),
      .sel (fwd_sel[i*SW +: SW])
    );
  end

  // a load is not yet forwardable in stages 0..LOAD_STAGE-2
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && id_src[i*AW +: AW] != '0) begin
        for (int k = 0; k <= DEPTH; k++) begin
          if (k <= LOAD_STAGE - 2 && wr_live(tag_q[k])
              && tag_q[k].is_load
              && tag_q[k].rd == RD_W'(id_src[i*AW +: AW]))
            ld_hit = 1'b1;
        end
      end
    end
    load_use_stall = id_valid & ~flush & ld_hit;
  end

  always_comb begin
    tag_d     = tag_q;
    ex_src_d  = ex_src_q;
    ex_used_d = ex_used_q;
    if (!ext_stall) begin
      for (int k = DEPTH; k >= 1; k--) tag_d[k] = tag_q[k-1];
      if (id_valid && !load_use_stall && !flush) begin
        tag_d[0].valid    = 1'b1;
        tag_d[0].regwrite = id_regwrite;
        tag_d[0].is_load  = id_is_load;
        tag_d[0].rd       = RD_W'(id_rd);
        ex_src_d          = id_src;
        ex_used_d         = id_src_used;
      end else begin
        tag_d[0]  = '0;
        ex_used_d = '0;
      end
    end else if (flush) begin
      tag_d[0].valid = 1'b0;
      ex_used_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DEPTH; k++) tag_q[k] <= '0;
      ex_src_q  <= '0;
      ex_used_q <= '0;
    end else begin
      for (int k = 0; k <= DEPTH; k++) tag_q[k] <= tag_d[k];
      ex_src_q  <= ex_src_d;
      ex_used_q <= ex_used_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_use_stall && !ext_stall && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two units (DEPTH 2/LS 2 and DEPTH 3/LS 3) against an
// age-based model of issued instructions.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid [2];
  logic       id_regwrite [2];
  logic       id_is_load [2];
  logic [4:0] id_rd [2];
  logic [9:0] id_src [2];
  logic [1:0] id_src_used [2];
  logic       ext_stall [2];
  logic       flush [2];
  logic [3:0] fwd_sel [2];
  logic       load_use_stall [2];
  logic [15:0] stall_cnt [2];

  fwd_hazard_unit #(.NUM_SRC(2), .AW(5), .DEPTH(2), .LOAD_STAGE(2)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid[0]), .id_regwrite(id_regwrite[0]),
    .id_is_load(id_is_load[0]), .id_rd(id_rd[0]),
    .id_src(id_src[0]), .id_src_used(id_src_used[0]),
    .ext_stall(ext_stall[0]), .flush(flush[0]),
    .fwd_sel(fwd_sel[0]), .load_use_stall(load_use_stall[0]),
    .stall_cnt(stall_cnt[0])
  );

  fwd_hazard_unit #(.NUM_SRC(2), .AW(5), .DEPTH(3), .LOAD_STAGE(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid[1]), .id_regwrite(id_regwrite[1]),
    .id_is_load(id_is_load[1]), .id_rd(id_rd[1]),
    .id_src(id_src[1]), .id_src_used(id_src_used[1]),
    .ext_stall(ext_stall[1]), .flush(flush[1]),
    .fwd_sel(fwd_sel[1]), .load_use_stall(load_use_stall[1]),
    .stall_cnt(stall_cnt[1])
  );

`ifdef FWD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int DEP [2] = '{2, 3};
  int LS  [2] = '{2, 3};

  typedef struct {
    int d;
    bit wr, ld;
    int rd, s0, s1;
    bit u0, u1;
    int entry;
  } ins_t;

  typedef struct {
    int    u;
    bit    chk_fwd;
    int    f0, f1;
    bit    st;
    int    cnt;
    string tag;
  } exp_t;

  ins_t hist[$];
  ins_t ex [2];
  bit   exv [2];
  int   adv [2];
  int   cnt [2];

  bit c_v [2], c_wr [2], c_ld [2], c_xs [2], c_fl [2], c_u0 [2], c_u1 [2];
  int c_rd [2], c_s0 [2], c_s1 [2];
  bit last_st [2];

  exp_t sb[$];
  event ev;
  int checks = 0;
  int errors = 0;
  string cur_tag = "reset";

  function automatic int exp_sel(int u, int s, bit used);
    int best = 0;
    int st;
    if (!used || s == 0) return 0;
    foreach (hist[j]) begin
      st = adv[u] - hist[j].entry;
      if (hist[j].d == u && hist[j].wr && hist[j].rd == s
          && st >= 1 && st <= DEP[u] && (best == 0 || st < best))
        best = st;
    end
    return best;
  endfunction

  function automatic bit hits_load(int u, int s);
    if (s == 0) return 1'b0;
    if (LS[u] - 2 >= 0 && exv[u] && ex[u].wr && ex[u].ld && ex[u].rd == s)
      return 1'b1;
    foreach (hist[j])
      if (hist[j].d == u && hist[j].wr && hist[j].ld && hist[j].rd == s
          && adv[u] - hist[j].entry <= LS[u] - 2)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall(int u);
    if (!c_v[u] || c_fl[u]) return 1'b0;
    return (c_u0[u] && hits_load(u, c_s0[u])) ||
           (c_u1[u] && hits_load(u, c_s1[u]));
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int u = 0; u < 2; u++) begin
      exv[u] = 1'b0;
      cnt[u] = 0;
    end
  endtask

  task automatic model_edge(int u, bit st);
    ins_t e;
    if (!c_xs[u]) begin
      if (exv[u]) begin
        e = ex[u];
        e.entry = adv[u];
        hist.push_back(e);
      end
      adv[u]++;
      for (int j = hist.size() - 1; j >= 0; j--)
        if (adv[hist[j].d] - hist[j].entry > DEP[hist[j].d]) hist.delete(j);
      if (c_v[u] && !st && !c_fl[u]) begin
        exv[u] = 1'b1;
        ex[u] = '{d: u, wr: c_wr[u], ld: c_ld[u], rd: c_rd[u], s0: c_s0[u],
                  s1: c_s1[u], u0: c_u0[u], u1: c_u1[u], entry: 0};
      end else begin
        exv[u] = 1'b0;
      end
      if (CNT_EN && st && cnt[u] < 65535) cnt[u]++;
    end else if (c_fl[u]) begin
      exv[u] = 1'b0;
    end
  endtask

  task automatic apply(int u);
    id_valid[u]    = c_v[u];
    id_regwrite[u] = c_wr[u];
    id_is_load[u]  = c_ld[u];
    id_rd[u]       = c_rd[u][4:0];
    id_src[u]      = {c_s1[u][4:0], c_s0[u][4:0]};
    id_src_used[u] = {c_u1[u], c_u0[u]};
    ext_stall[u]   = c_xs[u];
    flush[u]       = c_fl[u];
  endtask

  task automatic set_ins(int u, bit v, bit wr, bit ld, int rd,
                         int s0, bit u0, int s1, bit u1);
    c_v[u] = v; c_wr[u] = wr; c_ld[u] = ld; c_rd[u] = rd;
    c_s0[u] = s0; c_u0[u] = u0; c_s1[u] = s1; c_u1[u] = u1;
    c_xs[u] = 1'b0; c_fl[u] = 1'b0;
  endtask

  task automatic push_exp(int u, bit st);
    exp_t e;
    e.u = u;
    e.chk_fwd = exv[u];
    e.f0 = exv[u] ? exp_sel(u, ex[u].s0, ex[u].u0) : 0;
    e.f1 = exv[u] ? exp_sel(u, ex[u].s1, ex[u].u1) : 0;
    e.st = st;
    e.cnt = cnt[u];
    e.tag = cur_tag;
    sb.push_back(e);
  endtask

  task automatic cycle();
    bit st [2];
    @(negedge clk);
    apply(0);
    apply(1);
    #1;
    for (int u = 0; u < 2; u++) begin
      st[u] = exp_stall(u);
      push_exp(u, st[u]);
    end
    ->ev;
    @(posedge clk);
    if (rst_n)
      for (int u = 0; u < 2; u++) model_edge(u, st[u]);
    last_st = st;
  endtask

  // asserts reset a moment after a negedge and expects outputs cleared
  // before any clock edge arrives
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    apply(0);
    apply(1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    for (int u = 0; u < 2; u++) begin
      e = '{u: u, chk_fwd: 1'b1, f0: 0, f1: 0, st: 1'b0, cnt: 0,
            tag: cur_tag};
      sb.push_back(e);
    end
    ->ev;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    last_st = '{1'b0, 1'b0};
  endtask

  task automatic run_held(int max);
    int n = 0;
    cycle();
    while ((last_st[0] || last_st[1]) && n < max) begin
      cycle();
      n++;
    end
  endtask

  task automatic idle(int n);
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_ins(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin : monitor
    exp_t e;
    logic [1:0] a0, a1;
    forever begin
      @(ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a0 = fwd_sel[e.u][1:0];
        a1 = fwd_sel[e.u][3:2];
        checks++;
        if (load_use_stall[e.u] !== e.st) begin
          errors++;
          $display("FAIL %s d%0d stall got %b want %b",
                   e.tag, e.u, load_use_stall[e.u], e.st);
        end
        checks++;
        if (stall_cnt[e.u] !== 16'(e.cnt)) begin
          errors++;
          $display("FAIL %s d%0d stall_cnt got %0d want %0d",
                   e.tag, e.u, stall_cnt[e.u], e.cnt);
        end
        if (e.chk_fwd) begin
          checks++;
          if (a0 !== 2'(e.f0) || a1 !== 2'(e.f1)) begin
            errors++;
            $display("FAIL %s d%0d fwd_sel got %0d/%0d want %0d/%0d",
                     e.tag, e.u, a0, a1, e.f0, e.f1);
          end
        end
      end
    end
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      adv[u] = 0;
      set_ins(u, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(u);
    end
    model_reset();
    last_st = '{1'b0, 1'b0};
    do_reset();

    cur_tag = "add_sub";
    set_ins(0, 1, 1, 0, 3, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 4, 3, 1, 5, 1); cycle();
    set_ins(0, 1, 1, 0, 3, 0, 0, 0, 0); cycle();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 4, 5, 1, 3, 1); cycle();
    idle(3);

    cur_tag = "load_use";
    set_ins(0, 1, 1, 1, 7, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 8, 7, 1, 1, 1); run_held(4);
    idle(3);

    cur_tag = "prio_r0";
    set_ins(0, 1, 1, 0, 2, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 2, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 9, 2, 1, 2, 1); cycle();
    set_ins(0, 1, 1, 0, 0, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 9, 0, 1, 0, 1); cycle();
    idle(3);

    cur_tag = "ext_stall";
    set_ins(0, 1, 1, 0, 3, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 4, 3, 1, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 5, 0, 0, 0, 0);
    c_xs[0] = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    cur_tag = "flush";
    set_ins(0, 1, 1, 0, 6, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 1, 0, 0, 0, 0);
    c_xs[0] = 1'b1;
    c_fl[0] = 1'b1;
    cycle();
    set_ins(0, 1, 1, 0, 10, 6, 1, 0, 0); cycle();
    idle(3);

    cur_tag = "reset_mid";
    set_ins(0, 1, 1, 0, 3, 0, 0, 0, 0); cycle();
    set_ins(0, 1, 1, 1, 7, 3, 1, 0, 0); cycle();
    set_ins(0, 1, 1, 0, 8, 7, 1, 1, 1); cycle();
    do_reset();
    cur_tag = "after_rst";
    cycle();
    idle(3);

    cur_tag = "deep_load";
    set_ins(1, 1, 1, 1, 7, 0, 0, 0, 0); cycle();
    set_ins(1, 1, 1, 0, 8, 7, 1, 1, 1); run_held(5);
    idle(4);

    cur_tag = "random";
    for (int n = 0; n < 600; n++) begin
      for (int u = 0; u < 2; u++) begin
        if (!last_st[u]) begin
          set_ins(u, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end
        c_xs[u] = $urandom_range(0, 7) == 0;
        c_fl[u] = $urandom_range(0, 9) == 0;
      end
      cycle();
      if (n == 300) begin
        cur_tag = "rand_rst";
        do_reset();
        cur_tag = "random";
      end
    end
    idle(2);
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
